// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the byte-serial instruction fetch stage.
package if_fetch_pkg;

  localparam int InstAddrBusW = 32;
  localparam int InstBusW     = 32;
  localparam int StallBusW    = 6;
  localparam int StallIfId    = 1;

  localparam logic       ChipDisable = 1'b0;
  localparam logic       Stop        = 1'b1;
  localparam logic       NoStop      = 1'b0;
  localparam logic [2:0] IssueLimit  = 3'd4;
  localparam logic [1:0] LastByte    = 2'd3;

  typedef enum logic [1:0] {
    IfIdle  = 2'b00,
    IfFetch = 2'b01,
    IfHold  = 2'b10
  } if_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch over a byte-wide memory port: four byte reads per word,
// assembled little-endian for IF/ID, with pc frozen via stallreq_o until done.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter int ADDR_W = InstAddrBusW,
  parameter int INST_W = InstBusW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_W-1:0]    pc_i,
  input  logic                 ce_i,
  input  logic [StallBusW-1:0] stall_i,
  input  logic                 flush_i,
  input  logic                 mem_busy_i,
  input  logic [7:0]           mem_din_i,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_rd_o,
  output logic [INST_W-1:0]    inst_o,
  output logic [ADDR_W-1:0]    inst_pc_o,
  output logic                 inst_valid_o,
  output logic                 stallreq_o
);

  if_state_e         state;
  if_state_e         next_state;
  logic [2:0]        issue_cnt;
  logic [1:0]        recv_cnt;
  logic              pend;
  logic [INST_W-1:0] inst_buf;

  logic              abort;
  logic              hold_req;
  logic              in_fetch;
  logic              req;
  logic              last_byte;
  logic [INST_W-1:0] word;
  logic              unused_stall;

  assign unused_stall = ^{stall_i[StallBusW-1:StallIfId+1], stall_i[StallIfId-1:0]};

  // A dropped chip enable aborts exactly like a flush; only the next state differs.
  assign abort     = flush_i || (ce_i == ChipDisable);
  assign hold_req  = stall_i[StallIfId];
  assign in_fetch  = (state == IfFetch) && !abort;
  assign req       = in_fetch && (issue_cnt < IssueLimit) && !mem_busy_i;
  assign last_byte = in_fetch && pend && (recv_cnt == LastByte);
  assign word      = {mem_din_i, inst_buf[INST_W-9:0]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IfIdle;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (ce_i == ChipDisable) begin
      next_state = IfIdle;
    end else if (flush_i) begin
      next_state = IfFetch;
    end else begin
      case (state)
        IfIdle:  next_state = IfFetch;
        IfFetch: if (last_byte && hold_req) next_state = IfHold;
        IfHold:  if (!hold_req) next_state = IfFetch;
        default: next_state = IfIdle;
      endcase
    end
  end

  always_comb begin
    mem_rd_o     = 1'b0;
    mem_addr_o   = '0;
    inst_o       = '0;
    inst_pc_o    = '0;
    inst_valid_o = 1'b0;
    stallreq_o   = NoStop;
    case (state)
      IfFetch: begin
        if (!abort) begin
          mem_rd_o   = req;
          mem_addr_o = pc_i + ADDR_W'(issue_cnt);
          stallreq_o = last_byte ? NoStop : Stop;
          if (last_byte) begin
            inst_o       = word;
            inst_pc_o    = pc_i;
            inst_valid_o = 1'b1;
          end
        end
      end
      IfHold: begin
        if (!abort) begin
          inst_o       = inst_buf;
          inst_pc_o    = pc_i;
          inst_valid_o = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Counters restart whenever the word completes or the fetch is abandoned;
  // the held word is captured only when IF/ID cannot take it this cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      issue_cnt <= '0;
      recv_cnt  <= '0;
      pend      <= 1'b0;
      inst_buf  <= '0;
    end else if (!in_fetch) begin
      issue_cnt <= '0;
      recv_cnt  <= '0;
      pend      <= 1'b0;
    end else begin
      pend <= req;
      if (last_byte) begin
        issue_cnt <= '0;
        recv_cnt  <= '0;
        if (hold_req) begin
          inst_buf <= word;
        end
      end else begin
        issue_cnt <= issue_cnt + {2'b00, req};
        if (pend) begin
          inst_buf[8*recv_cnt +: 8] <= mem_din_i;
          recv_cnt                  <= recv_cnt + 2'd1;
        end
      end
    end
  end

  // A completed word never coincides with a new request, and no byte arrives
  // ahead of the request that produced it.
  assert property (@(posedge clk) disable iff (!rst) inst_valid_o |-> !mem_rd_o);
  assert property (@(posedge clk) disable iff (!rst) ({1'b0, recv_cnt} <= issue_cnt));

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: fetch transactions are planned from the
// fetch rules, expectations queued as they are driven, a negedge monitor checks.
module tb_if_fetch;

  typedef struct {
    int          cyc;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_i;
  logic        ce_i;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        mem_busy_i;
  logic [7:0]  mem_din_i;
  logic [31:0] mem_addr_o;
  logic        mem_rd_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        stallreq_o;

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  exp_t        valid_q[$];
  exp_t        req_q[$];
  exp_t        stall_q[$];
  bit          from_idle;
  logic [31:0] next_pc;

  if_fetch dut (
    .clk(clk), .rst(rst), .pc_i(pc_i), .ce_i(ce_i), .stall_i(stall_i),
    .flush_i(flush_i), .mem_busy_i(mem_busy_i), .mem_din_i(mem_din_i),
    .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .inst_o(inst_o),
    .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Instruction memory: fixed bytes 13 05 00 00 at address 0, hashed content elsewhere.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [31:0] h;
    case (a)
      32'h0:        return 8'h13;
      32'h1:        return 8'h05;
      32'h2, 32'h3: return 8'h00;
      default: begin
        h = a * 32'h9E3779B1;
        return h[31:24] ^ h[7:0];
      end
    endcase
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return {mem_byte(pc + 32'd3), mem_byte(pc + 32'd2), mem_byte(pc + 32'd1), mem_byte(pc)};
  endfunction

  function automatic exp_t mk(input int c, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    e.cyc = c;
    e.a   = a;
    e.b   = b;
    return e;
  endfunction

  // Byte returned the cycle after a request; garbage otherwise.
  always @(posedge clk) mem_din_i <= mem_rd_o ? mem_byte(mem_addr_o) : 8'($urandom);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %h, expected %h", name, cyc, actual, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_mem_rd"}, 32'(mem_rd_o), 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    checkOutput({tag, "_inst"}, inst_o, 32'd0);
    checkOutput({tag, "_inst_pc"}, inst_pc_o, 32'd0);
    checkOutput({tag, "_inst_valid"}, 32'(inst_valid_o), 32'd0);
    checkOutput({tag, "_stallreq"}, 32'(stallreq_o), 32'd0);
  endtask

  // Monitor: every cycle out of reset, compare presented outputs with queued expectations.
  always @(negedge clk) begin
    exp_t e;
    bit   want;
    if (rst) begin
      want = (valid_q.size() > 0) && (valid_q[0].cyc == cyc);
      checkOutput("inst_valid", 32'(inst_valid_o), 32'(want));
      if (want) begin
        e = valid_q.pop_front();
        if (inst_valid_o) begin
          checkOutput("inst", inst_o, e.a);
          checkOutput("inst_pc", inst_pc_o, e.b);
        end
      end
      want = (req_q.size() > 0) && (req_q[0].cyc == cyc);
      checkOutput("mem_rd", 32'(mem_rd_o), 32'(want));
      if (want) begin
        e = req_q.pop_front();
        if (mem_rd_o) checkOutput("mem_addr", mem_addr_o, e.a);
      end
      if (stall_q.size() > 0 && stall_q[0].cyc == cyc) begin
        e = stall_q.pop_front();
        checkOutput("stallreq", 32'(stallreq_o), e.a);
      end
    end
  end

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      ce_i       = 1'b0;
      flush_i    = 1'b0;
      mem_busy_i = 1'($urandom);
      stall_i    = 6'($urandom);
      stall_q.push_back(mk(cyc, 32'd0, 32'd0));
    end
  endtask

  // From IDLE, one cycle with ce high passes before the first request.
  task automatic enterFromIdle(input logic [31:0] pc);
    if (from_idle) begin
      @(posedge clk); #1;
      ce_i       = 1'b1;
      pc_i       = pc;
      flush_i    = 1'b0;
      mem_busy_i = 1'($urandom);
      stall_i    = 6'($urandom);
      stall_q.push_back(mk(cyc, 32'd0, 32'd0));
      from_idle  = 1'b0;
    end
  endtask

  // One fetch: bit t of busy_pat refuses the request at offset t; the word is
  // presented one cycle after the 4th accepted request and held n_stall extra
  // cycles. flush_at >= 0 aborts at that offset by flush (or ce drop).
  task automatic applyStimulus(input logic [31:0] pc, input logic [15:0] busy_pat, input int n_stall,
                               input int flush_at, input bit ce_drop, input logic [31:0] new_pc);
    int accepted;
    int v;
    int fa;
    int last_t;
    bit abort_now;
    bit busy_b;
    enterFromIdle(pc);
    accepted = 0;
    v = 0;
    for (int i = 0; i < 40 && accepted < 4; i++) begin
      if (!(i < 16 && busy_pat[i])) begin
        accepted++;
        if (accepted == 4) v = i + 1;
      end
    end
    fa     = (flush_at > v + n_stall) ? -1 : flush_at;
    last_t = (fa >= 0) ? fa : v + n_stall;
    accepted = 0;
    for (int t = 0; t <= last_t; t++) begin
      abort_now = (t == fa);
      busy_b    = (t < 16) ? busy_pat[t] : 1'b0;
      @(posedge clk); #1;
      pc_i       = pc;
      ce_i       = !(abort_now && ce_drop);
      flush_i    = abort_now && !ce_drop;
      mem_busy_i = busy_b;
      stall_i    = 6'($urandom);
      if (t >= v) stall_i[1] = (t < v + n_stall);
      if (!abort_now && accepted < 4 && !busy_b) begin
        req_q.push_back(mk(cyc, pc + 32'(accepted), 32'd0));
        accepted++;
      end
      if (!abort_now && t >= v) valid_q.push_back(mk(cyc, word_at(pc), pc));
      stall_q.push_back(mk(cyc, 32'(!abort_now && t < v), 32'd0));
    end
    if (fa < 0) begin
      next_pc = pc + 32'd4;
    end else begin
      next_pc = new_pc;
      if (ce_drop) begin
        idleCycles($urandom_range(0, 2));
        from_idle = 1'b1;
      end
    end
  endtask

  // Two requests issued, then reset asserted between edges.
  task automatic resetMidFetch(input logic [31:0] pc);
    enterFromIdle(pc);
    for (int t = 0; t < 2; t++) begin
      @(posedge clk); #1;
      pc_i = pc; ce_i = 1'b1; flush_i = 1'b0; mem_busy_i = 1'b0; stall_i = 6'd0;
      req_q.push_back(mk(cyc, pc + 32'(t), 32'd0));
      stall_q.push_back(mk(cyc, 32'd1, 32'd0));
    end
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    checkAllZero("async_reset");
    ce_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    from_idle = 1'b1;
  endtask

  initial begin
    logic [31:0] pc;
    logic [15:0] bp;
    int          r;
    int          ns;
    int          fa;
    bit          cd;
    rst = 1'b1; ce_i = 1'b1; pc_i = 32'h1234; stall_i = 6'd0;
    flush_i = 1'b0; mem_busy_i = 1'b0; from_idle = 1'b1; next_pc = 32'd0;
    #1 rst = 1'b0;
    #2 checkAllZero("reset");
    repeat (2) @(posedge clk);
    #1 ce_i = 1'b0; rst = 1'b1;

    applyStimulus(32'h0, 16'h0000, 0, -1, 1'b0, 32'd0);
    applyStimulus(next_pc, 16'h0006, 0, -1, 1'b0, 32'd0);
    applyStimulus(next_pc, 16'h0000, 3, -1, 1'b0, 32'd0);
    applyStimulus(next_pc, 16'h0000, 0, -1, 1'b0, 32'd0);
    applyStimulus(next_pc, 16'h0000, 0, 3, 1'b0, 32'h100);
    applyStimulus(next_pc, 16'h0000, 0, -1, 1'b0, 32'd0);
    resetMidFetch(next_pc);
    applyStimulus(next_pc, 16'h0000, 0, 0, 1'b0, 32'hFFFFFFFC);
    applyStimulus(next_pc, 16'h0000, 0, -1, 1'b0, 32'd0);
    applyStimulus(next_pc, 16'h0000, 0, -1, 1'b0, 32'd0);
    applyStimulus(next_pc, 16'h0000, 3, 6, 1'b0, 32'hFFFFFFFE);
    applyStimulus(next_pc, 16'h0009, 1, -1, 1'b0, 32'd0);
    applyStimulus(next_pc, 16'h0000, 0, 2, 1'b1, 32'h40);
    applyStimulus(next_pc, 16'h0000, 0, -1, 1'b0, 32'd0);

    for (int n = 0; n < 300; n++) begin
      r  = $urandom_range(0, 9);
      pc = (r < 6) ? next_pc : ((r < 8) ? $urandom : 32'hFFFFFFFC + 32'($urandom_range(0, 3)));
      bp = 16'($urandom & $urandom & $urandom);
      ns = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
      r  = $urandom_range(0, 9);
      fa = (r < 3) ? $urandom_range(0, 8) : -1;
      cd = (r == 0);
      applyStimulus(pc, bp, ns, fa, cd, $urandom);
    end

    idleCycles(3);
    @(posedge clk); #1;
    checkOutput("queue_drain", 32'(valid_q.size() + req_q.size() + stall_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
